// File: rtl/io_pkg.sv
// -----------------------------------------------------------------------------
// io_pkg
// Shared definitions for the ODE-solver IO block (loading and read-back paths).
//   - io_state_e : packet decoder FSM states
//   - header field positions inside a 32-bit CPU bus word
//   - BUS_WIDTH  : CPU bus word width
// -----------------------------------------------------------------------------
package io_pkg;

    localparam int BUS_WIDTH   = 32;

    // Header word layout: [COUNT_MSB:COUNT_LSB] = word count N,
    // [ADDR_MSB:0] = base address (only the low RAM-address bits are used).
    localparam int COUNT_MSB   = 31;
    localparam int COUNT_LSB   = 16;
    localparam int ADDR_MSB    = 15;
    localparam int COUNT_WIDTH = COUNT_MSB - COUNT_LSB + 1;

    typedef enum logic [1:0] {
        ST_HEADER = 2'd0,
        ST_LOW    = 2'd1,
        ST_HIGH   = 2'd2,
        ST_DONE   = 2'd3
    } io_state_e;

endpackage : io_pkg

// File: rtl/decoder_receiver.sv
// -----------------------------------------------------------------------------
// decoder_receiver
// Loading half of the ODE-solver IO block. Decodes a stream of 32-bit CPU bus
// words into packets (header + pairs of data halves), assembles DATA_WIDTH-bit
// words and writes them into solver RAM.
//
// Ports:
//   CLK                            in   system clock, rising edge
//   RST                            in   asynchronous active-low reset
//   CPU_Bus[31:0]                  in   CPU data word
//   Loading_Enable                 in   word-valid strobe
//   Done_Loading                   out  sticky end-of-load flag
//   Done_Processing_Current_Packet out  one-cycle pulse with a packet's last write
//   Memory_WR_Enable               out  RAM write strobe
//   Memory_Address_WR              out  RAM write address
//   Memory_Data_WR                 out  RAM write data
//
// Handshake: Loading_Enable is a pure valid with no back-pressure. A word is
// consumed on every rising CLK edge where Loading_Enable=1; the block is always
// ready. With Loading_Enable=0 all state holds indefinitely.
//
// The FSM state is kept in state_q so checkers can bind to it directly.
// -----------------------------------------------------------------------------
module decoder_receiver
    import io_pkg::*;
#(
    parameter int ADDRESS_WIDTH = 13,
    parameter int DATA_WIDTH    = 64   // must be 2 * BUS_WIDTH
) (
    input  logic                     CLK,
    input  logic                     RST,
    input  logic [BUS_WIDTH-1:0]     CPU_Bus,
    input  logic                     Loading_Enable,
    output logic                     Done_Loading,
    output logic                     Done_Processing_Current_Packet,
    output logic                     Memory_WR_Enable,
    output logic [ADDRESS_WIDTH-1:0] Memory_Address_WR,
    output logic [DATA_WIDTH-1:0]    Memory_Data_WR
);

    io_state_e                state_q,        state_d;
    logic [COUNT_WIDTH-1:0]   count_q,        count_d;
    logic [COUNT_WIDTH-1:0]   idx_q,          idx_d;
    logic [ADDRESS_WIDTH-1:0] base_q,         base_d;
    logic [BUS_WIDTH-1:0]     lo_q,           lo_d;
    logic                     wr_en_q,        wr_en_d;
    logic [ADDRESS_WIDTH-1:0] wr_addr_q,      wr_addr_d;
    logic [DATA_WIDTH-1:0]    wr_data_q,      wr_data_d;
    logic                     pkt_done_q,     pkt_done_d;
    logic                     done_loading_q, done_loading_d;

    logic [COUNT_WIDTH-1:0]   idx_inc;
    logic [COUNT_WIDTH-1:0]   hdr_count;

    assign idx_inc   = idx_q + 1'b1;
    assign hdr_count = CPU_Bus[COUNT_MSB:COUNT_LSB];

    always_comb begin
        state_d        = state_q;
        count_d        = count_q;
        idx_d          = idx_q;
        base_d         = base_q;
        lo_d           = lo_q;
        wr_en_d        = 1'b0;
        wr_addr_d      = wr_addr_q;   // address/data hold between writes
        wr_data_d      = wr_data_q;
        pkt_done_d     = 1'b0;
        done_loading_d = done_loading_q;

        if (Loading_Enable) begin
            case (state_q)
                ST_HEADER: begin
                    if (hdr_count == '0) begin
                        // N=0 is the end-of-load marker
                        done_loading_d = 1'b1;
                        state_d        = ST_DONE;
                    end else begin
                        count_d = hdr_count;
                        base_d  = CPU_Bus[ADDRESS_WIDTH-1:0];
                        idx_d   = '0;
                        state_d = ST_LOW;
                    end
                end
                ST_LOW: begin
                    lo_d    = CPU_Bus;
                    state_d = ST_HIGH;
                end
                ST_HIGH: begin
                    // Address sum is ADDRESS_WIDTH bits wide, so it wraps
                    // modulo the RAM depth.
                    wr_en_d   = 1'b1;
                    wr_addr_d = base_q + idx_q[ADDRESS_WIDTH-1:0];
                    wr_data_d = {CPU_Bus, lo_q};
                    idx_d     = idx_inc;
                    if (idx_inc == count_q) begin
                        pkt_done_d = 1'b1;
                        state_d    = ST_HEADER;
                    end else begin
                        state_d    = ST_LOW;
                    end
                end
                ST_DONE: begin
                    // all words ignored until reset
                end
                default: begin
                    state_d = ST_HEADER;
                end
            endcase
        end
    end

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            state_q        <= ST_HEADER;
            count_q        <= '0;
            idx_q          <= '0;
            base_q         <= '0;
            lo_q           <= '0;
            wr_en_q        <= 1'b0;
            wr_addr_q      <= '0;
            wr_data_q      <= '0;
            pkt_done_q     <= 1'b0;
            done_loading_q <= 1'b0;
        end else begin
            state_q        <= state_d;
            count_q        <= count_d;
            idx_q          <= idx_d;
            base_q         <= base_d;
            lo_q           <= lo_d;
            wr_en_q        <= wr_en_d;
            wr_addr_q      <= wr_addr_d;
            wr_data_q      <= wr_data_d;
            pkt_done_q     <= pkt_done_d;
            done_loading_q <= done_loading_d;
        end
    end

    assign Done_Loading                   = done_loading_q;
    assign Done_Processing_Current_Packet = pkt_done_q;
    assign Memory_WR_Enable               = wr_en_q;
    assign Memory_Address_WR              = wr_addr_q;
    assign Memory_Data_WR                 = wr_data_q;

endmodule : decoder_receiver

// File: tb/tb_decoder_receiver.sv
// -----------------------------------------------------------------------------
// tb_decoder_receiver
// Directed testbench for decoder_receiver. Expected RAM writes are pushed into
// a scoreboard queue as {addr, data, last}; a negedge monitor pops and compares
// every observed write.
// -----------------------------------------------------------------------------
module tb_decoder_receiver;

    localparam int AW = 13;
    localparam int DW = 64;
    localparam int EW = AW + DW + 1;

    logic          CLK;
    logic          RST;
    logic [31:0]   CPU_Bus;
    logic          Loading_Enable;
    logic          Done_Loading;
    logic          Done_Processing_Current_Packet;
    logic          Memory_WR_Enable;
    logic [AW-1:0] Memory_Address_WR;
    logic [DW-1:0] Memory_Data_WR;

    int check_count = 0;
    int error_count = 0;
    int wr_pulses   = 0;
    int done_pulses = 0;

    logic [EW-1:0] exp_q[$];

    decoder_receiver #(
        .ADDRESS_WIDTH(AW),
        .DATA_WIDTH   (DW)
    ) dut (
        .CLK                           (CLK),
        .RST                           (RST),
        .CPU_Bus                       (CPU_Bus),
        .Loading_Enable                (Loading_Enable),
        .Done_Loading                  (Done_Loading),
        .Done_Processing_Current_Packet(Done_Processing_Current_Packet),
        .Memory_WR_Enable              (Memory_WR_Enable),
        .Memory_Address_WR             (Memory_Address_WR),
        .Memory_Data_WR                (Memory_Data_WR)
    );

    // ---------------- clock / reset ----------------
    initial begin
        CLK = 1'b0;
        forever #5 CLK = ~CLK;
    end

    // ---------------- checking ----------------
    task automatic check_value(input string tag, input logic [63:0] obs,
                               input logic [63:0] exp);
        check_count++;
        if (obs !== exp) begin
            error_count++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    // ---------------- drivers ----------------
    task automatic send_word(input logic [31:0] w);
        @(negedge CLK);
        CPU_Bus        = w;
        Loading_Enable = 1'b1;
        @(posedge CLK);
        #1;
        Loading_Enable = 1'b0;
    endtask

    task automatic idle(input int n);
        Loading_Enable = 1'b0;
        repeat (n) @(posedge CLK);
        #1;
    endtask

    task automatic expect_write(input logic [AW-1:0] a, input logic [63:0] d,
                                input logic last);
        exp_q.push_back({a, d, last});
    endtask

    // ---------------- scoreboard monitor ----------------
    always @(negedge CLK) begin
        logic [EW-1:0] e;
        if (RST === 1'b1) begin
            if (Done_Processing_Current_Packet) done_pulses++;
            if (Memory_WR_Enable) begin
                wr_pulses++;
                check_value("write_expected", 64'(exp_q.size() != 0), 64'd1);
                if (exp_q.size() != 0) begin
                    e = exp_q.pop_front();
                    check_value("wr_addr", 64'(Memory_Address_WR), 64'(e[EW-1 -: AW]));
                    check_value("wr_data", Memory_Data_WR, e[DW:1]);
                    check_value("wr_last", 64'(Done_Processing_Current_Packet), 64'(e[0]));
                end
            end
        end
    end

    // ---------------- stimulus ----------------
    int wr0, dn0;

    initial begin
        RST            = 1'b0;
        CPU_Bus        = '0;
        Loading_Enable = 1'b0;
        repeat (3) @(posedge CLK);
        #1;
        check_value("rst_wr_en",   64'(Memory_WR_Enable), 64'd0);
        check_value("rst_addr",    64'(Memory_Address_WR), 64'd0);
        check_value("rst_data",    Memory_Data_WR, 64'd0);
        check_value("rst_pkt_done", 64'(Done_Processing_Current_Packet), 64'd0);
        check_value("rst_done_ld", 64'(Done_Loading), 64'd0);
        @(negedge CLK);
        RST = 1'b1;

        // Single packet with exact latency checks
        expect_write(13'h010, 64'h01234567_DEADBEEF, 1'b1);
        send_word(32'h0001_0010);
        send_word(32'hDEADBEEF);
        check_value("lat_no_early_wr", 64'(Memory_WR_Enable), 64'd0);
        send_word(32'h01234567);
        check_value("lat_wr_en",    64'(Memory_WR_Enable), 64'd1);
        check_value("lat_pkt_done", 64'(Done_Processing_Current_Packet), 64'd1);
        @(posedge CLK);
        #1;
        check_value("wr_one_cycle",   64'(Memory_WR_Enable), 64'd0);
        check_value("done_one_cycle", 64'(Done_Processing_Current_Packet), 64'd0);
        check_value("addr_hold", 64'(Memory_Address_WR), 64'h010);
        check_value("data_hold", Memory_Data_WR, 64'h01234567_DEADBEEF);

        // Async reset while in HIGH: partial packet discarded
        send_word(32'h0001_0030);
        send_word(32'h5555_5555);
        @(posedge CLK);
        #3;
        RST = 1'b0;
        #1;
        check_value("mid_rst_addr", 64'(Memory_Address_WR), 64'd0);
        check_value("mid_rst_data", Memory_Data_WR, 64'd0);
        check_value("mid_rst_wr",   64'(Memory_WR_Enable), 64'd0);
        @(negedge CLK);
        RST = 1'b1;

        // Stalled 2-word packet with address wrap
        wr0 = wr_pulses;
        dn0 = done_pulses;
        expect_write(13'h1FFF, 64'h2222_2222_1111_1111, 1'b0);
        expect_write(13'h0000, 64'h4444_4444_3333_3333, 1'b1);
        send_word(32'h0002_1FFF); idle(3);
        send_word(32'h1111_1111); idle(3);
        send_word(32'h2222_2222); idle(3);
        send_word(32'h3333_3333); idle(3);
        send_word(32'h4444_4444); idle(3);
        check_value("stall_wr_count",   64'(wr_pulses - wr0), 64'd2);
        check_value("stall_done_count", 64'(done_pulses - dn0), 64'd1);
        check_value("stall_drained",    64'(exp_q.size()), 64'd0);

        // Back-to-back packets, no idle between them
        wr0 = wr_pulses;
        dn0 = done_pulses;
        expect_write(13'h020, 64'hBBBB_0002_AAAA_0001, 1'b1);
        expect_write(13'h005, 64'hDDDD_0004_CCCC_0003, 1'b1);
        send_word(32'h0001_0020);
        send_word(32'hAAAA_0001);
        send_word(32'hBBBB_0002);
        send_word(32'h0001_0005);
        send_word(32'hCCCC_0003);
        send_word(32'hDDDD_0004);
        idle(2);
        check_value("b2b_wr_count",   64'(wr_pulses - wr0), 64'd2);
        check_value("b2b_done_count", 64'(done_pulses - dn0), 64'd2);
        check_value("b2b_drained",    64'(exp_q.size()), 64'd0);

        // Base address masking: 0xFFFF -> 0x1FFF
        expect_write(13'h1FFF, 64'h8765_4321_0F0F_F0F0, 1'b1);
        send_word(32'h0001_FFFF);
        send_word(32'h0F0F_F0F0);
        send_word(32'h8765_4321);
        idle(2);
        check_value("mask_drained", 64'(exp_q.size()), 64'd0);

        // End marker, then ignored words
        check_value("pre_end_done_ld", 64'(Done_Loading), 64'd0);
        send_word(32'h0000_0000);
        check_value("end_done_ld", 64'(Done_Loading), 64'd1);
        wr0 = wr_pulses;
        send_word(32'h0001_0000);
        send_word(32'h1111_1111);
        send_word(32'h2222_2222);
        idle(3);
        check_value("end_done_sticky", 64'(Done_Loading), 64'd1);
        check_value("end_no_writes",   64'(wr_pulses - wr0), 64'd0);

        check_value("total_wr",   64'(wr_pulses), 64'd6);
        check_value("total_done", 64'(done_pulses), 64'd5);
        check_value("final_drained", 64'(exp_q.size()), 64'd0);

        $display("Simulation finished: %0d checks, %0d errors", check_count, error_count);
        $finish;
    end

endmodule : tb_decoder_receiver
